// File: rtl/cpu_bus_pkg.sv
// Shared types for the CPU memory bus: responder FSM states, cycle kinds and
// width defaults used by the bus interface and the memory-side responder.
package cpu_bus_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CYC_RD  = 2'd0,
    CYC_WR  = 2'd1,
    CYC_VEC = 2'd2
  } cyc_e;

  // A vector cycle overrides the read/write direction.
  function automatic cyc_e decode_cyc(input logic mirq_n, input logic r_w_n);
    if (!mirq_n) return CYC_VEC;
    return r_w_n ? CYC_RD : CYC_WR;
  endfunction

endpackage

// File: rtl/mem_bus_responder_if.sv
// CPU memory bus: request side driven by the CPU/decoder, response side by the
// memory responder.
interface mem_bus_responder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) ();

  logic              MREQ_N;
  logic              R_W_N;
  logic              MIRQ_N;
  logic [ADDR_W-1:0] ADDR;
  logic [DATA_W-1:0] WDATA;
  logic [DATA_W-1:0] IRQ_VEC;
  logic [DATA_W-1:0] M_BUS;
  logic              MACK;
  logic              BUS_ERR;

  modport master (
    output MREQ_N, R_W_N, MIRQ_N, ADDR, WDATA, IRQ_VEC,
    input  M_BUS, MACK, BUS_ERR
  );

  modport slave (
    input  MREQ_N, R_W_N, MIRQ_N, ADDR, WDATA, IRQ_VEC,
    output M_BUS, MACK, BUS_ERR
  );

endinterface

// File: rtl/word_ram.sv
// Single-port-per-direction word RAM: synchronous write, registered read that
// only updates when re is asserted.
module word_ram #(
  parameter int    DATA_W    = 16,
  parameter int    DEPTH     = 4096,
  parameter int    IDX_W     = 12,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are never reset; rdata holds its last value while re is low.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder for the CPU bus: latches a request, inserts wait
// states, then acknowledges with read data, an interrupt vector or a bus error.
module mem_bus_responder
  import cpu_bus_pkg::*;
#(
  parameter int    DATA_W    = DATA_W_DEF,
  parameter int    ADDR_W    = ADDR_W_DEF,
  parameter int    DEPTH     = 4096,
  parameter int    WAIT_CYC  = 2,
  parameter string INIT_FILE = ""
) (
  input logic               CLK,
  input logic               CLR,
  mem_bus_responder_if.slave bus
);

  localparam int        IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  cyc_e              cyc_q, cyc_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              mack_q, mack_d;
  logic              bus_err_q, bus_err_d;
  logic [DATA_W-1:0] m_bus_q, m_bus_d;
  logic              rd_sel_q, rd_sel_d;

  logic              enter_ack;
  cyc_e              req_cyc;
  logic              req_err;
  logic              ram_we;
  logic              ram_re;
  logic [IDX_W-1:0]  ram_idx;
  logic [DATA_W-1:0] ram_rdata;

  function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
    return 32'(a) >= 32'(DEPTH);
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cyc_d     = cyc_q;
    err_d     = err_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    m_bus_d   = m_bus_q;
    rd_sel_d  = rd_sel_q;
    enter_ack = 1'b0;

    req_cyc = decode_cyc(bus.MIRQ_N, bus.R_W_N);
    req_err = (req_cyc != CYC_VEC) && out_of_range(bus.ADDR);

    unique case (state_q)
      IDLE: begin
        if (!bus.MREQ_N) begin
          addr_d  = bus.ADDR;
          wdata_d = bus.WDATA;
          cyc_d   = req_cyc;
          err_d   = req_err;
          cnt_d   = WAIT_INIT;
          if (WAIT_CYC == 0) begin
            state_d   = ACK;
            enter_ack = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // Dropping the request during wait states abandons the cycle silently.
        if (bus.MREQ_N) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd1) begin
          state_d   = ACK;
          enter_ack = 1'b1;
          cnt_d     = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK: begin
        if (bus.MREQ_N) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Response fields are captured once on ACK entry and held until release.
    mack_d    = (state_d == ACK);
    bus_err_d = (state_d == ACK) && err_d;
    if (enter_ack) begin
      m_bus_d  = (cyc_d == CYC_VEC) ? bus.IRQ_VEC : '0;
      rd_sel_d = (cyc_d == CYC_RD) && !err_d;
    end else if (state_d != ACK) begin
      m_bus_d  = '0;
      rd_sel_d = 1'b0;
    end

    ram_idx = IDX_W'(addr_d);
    ram_we  = enter_ack && (cyc_d == CYC_WR) && !err_d && !CLR;
    ram_re  = enter_ack && (cyc_d == CYC_RD) && !err_d;
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      cyc_q     <= CYC_RD;
      err_q     <= 1'b0;
      mack_q    <= 1'b0;
      bus_err_q <= 1'b0;
      m_bus_q   <= '0;
      rd_sel_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cyc_q     <= cyc_d;
      err_q     <= err_d;
      mack_q    <= mack_d;
      bus_err_q <= bus_err_d;
      m_bus_q   <= m_bus_d;
      rd_sel_q  <= rd_sel_d;
    end
  end

  always_ff @(posedge CLK) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  word_ram #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .IDX_W    (IDX_W),
    .INIT_FILE(INIT_FILE)
  ) u_ram (
    .clk  (CLK),
    .we   (ram_we),
    .waddr(ram_idx),
    .wdata(wdata_d),
    .re   (ram_re),
    .raddr(ram_idx),
    .rdata(ram_rdata)
  );

  assign bus.M_BUS   = rd_sel_q ? ram_rdata : m_bus_q;
  assign bus.MACK    = mack_q;
  assign bus.BUS_ERR = bus_err_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Randomized bench for mem_bus_responder against an array-based memory model;
// a second instance with no wait states covers zero-latency acknowledge.
module tb_mem_bus_responder;
  import cpu_bus_pkg::*;

  localparam int DW    = 16;
  localparam int AW    = 16;
  localparam int DEPTH = 4096;
  localparam int WC    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_bus_responder_if #(.DATA_W(DW), .ADDR_W(AW)) bi ();
  mem_bus_responder_if #(.DATA_W(DW), .ADDR_W(AW)) bz ();

  mem_bus_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_CYC(WC), .INIT_FILE(""))
    dut (.CLK(clk), .CLR(rst), .bus(bi));

  mem_bus_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_CYC(0), .INIT_FILE(""))
    dut_z (.CLK(clk), .CLR(rst), .bus(bz));

  int checks   = 0;
  int failures = 0;
  logic [15:0] model [int];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected response derived from the cycle-type priority rules.
  function automatic logic [15:0] exp_data(input logic rw, input logic mirq, input logic [15:0] a,
                                           input logic [15:0] vec, output logic err, output logic known);
    err = 1'b0; known = 1'b1;
    if (!mirq) return vec;
    if (int'(a) >= DEPTH) begin err = 1'b1; return 16'h0; end
    if (!rw) return 16'h0;
    known = model.exists(int'(a));
    return known ? model[int'(a)] : 16'h0;
  endfunction

  task automatic drive_req(input logic rw, input logic mirq, input logic [15:0] a,
                           input logic [15:0] wd, input logic [15:0] vec);
    @(negedge clk);
    bi.MREQ_N = 1'b0; bi.R_W_N = rw; bi.MIRQ_N = mirq;
    bi.ADDR = a; bi.WDATA = wd; bi.IRQ_VEC = vec;
  endtask

  task automatic txn(input string tag, input logic rw, input logic mirq, input logic [15:0] a,
                     input logic [15:0] wd, input logic [15:0] vec);
    logic err, known;
    logic [15:0] exp;
    int edges;
    exp = exp_data(rw, mirq, a, vec, err, known);
    drive_req(rw, mirq, a, wd, vec);
    @(posedge clk); edges = 1;
    @(negedge clk);
    bi.ADDR = 16'($urandom); bi.WDATA = 16'($urandom); bi.R_W_N = 1'($urandom);
    while (!bi.MACK && edges < 20) begin
      @(posedge clk); edges++; @(negedge clk);
    end
    chk({tag, ".lat"}, edges, WC + 1);
    if (bi.MACK) begin
      chk({tag, ".err"}, bi.BUS_ERR, err);
      if (known) chk({tag, ".data"}, bi.M_BUS, exp);
      @(posedge clk); @(negedge clk);
      chk({tag, ".hold"}, {bi.MACK, bi.BUS_ERR}, {1'b1, err});
      if (known) chk({tag, ".holddata"}, bi.M_BUS, exp);
    end
    bi.MREQ_N = 1'b1;
    @(posedge clk); @(negedge clk);
    chk({tag, ".rel"}, {bi.MACK, bi.BUS_ERR, bi.M_BUS}, 18'h0);
    if (!rw && mirq && !err) model[int'(a)] = wd;
  endtask

  task automatic abort_txn(input logic [15:0] a, input logic [15:0] wd, input int j);
    drive_req(1'b0, 1'b1, a, wd, 16'h0);
    repeat (j + 1) begin
      @(posedge clk); @(negedge clk);
      chk("abort.wait", bi.MACK, 1'b0);
    end
    bi.MREQ_N = 1'b1;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      chk("abort.idle", bi.MACK, 1'b0);
    end
  endtask

  task automatic clr_at_write_entry(input logic [15:0] a, input logic [15:0] wd);
    drive_req(1'b0, 1'b1, a, wd, 16'h0);
    @(posedge clk); @(negedge clk);
    repeat (WC - 1) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("clrwr.mack", {bi.MACK, bi.BUS_ERR, bi.M_BUS}, 18'h0);
    rst = 1'b0; bi.MREQ_N = 1'b1;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic clr_in_read_ack(input logic [15:0] a);
    int edges;
    drive_req(1'b1, 1'b1, a, 16'h0, 16'h0);
    edges = 0;
    do begin @(posedge clk); edges++; @(negedge clk); end while (!bi.MACK && edges < 20);
    chk("clrrd.ack", bi.MACK, 1'b1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("clrrd.out", {bi.MACK, bi.BUS_ERR, bi.M_BUS}, 18'h0);
    rst = 1'b0; bi.MREQ_N = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("clrrd.idle", bi.MACK, 1'b0);
  endtask

  task automatic ztxn(input string tag, input logic rw, input logic [15:0] a,
                      input logic [15:0] wd, input logic [15:0] exp);
    @(negedge clk);
    bz.MREQ_N = 1'b0; bz.R_W_N = rw; bz.MIRQ_N = 1'b1; bz.ADDR = a; bz.WDATA = wd;
    @(posedge clk); @(negedge clk);
    chk({tag, ".mack"}, bz.MACK, 1'b1);
    chk({tag, ".data"}, bz.M_BUS, exp);
    bz.MREQ_N = 1'b1;
    @(posedge clk); @(negedge clk);
    chk({tag, ".rel"}, bz.MACK, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] a, wd, v;
    int r;
    bi.MREQ_N = 1'b1; bi.R_W_N = 1'b1; bi.MIRQ_N = 1'b1;
    bi.ADDR = '0; bi.WDATA = '0; bi.IRQ_VEC = '0;
    bz.MREQ_N = 1'b1; bz.R_W_N = 1'b1; bz.MIRQ_N = 1'b1;
    bz.ADDR = '0; bz.WDATA = '0; bz.IRQ_VEC = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.out", {bi.MACK, bi.BUS_ERR, bi.M_BUS}, 18'h0);
    chk("reset.outz", {bz.MACK, bz.BUS_ERR, bz.M_BUS}, 18'h0);
    rst = 1'b0;

    txn("t1.wr", 1'b0, 1'b1, 16'h0010, 16'h1234, 16'h0);
    txn("t1.rd", 1'b1, 1'b1, 16'h0010, 16'h0, 16'h0);

    txn("t2.wrn", 1'b0, 1'b1, 16'h0021, 16'h1111, 16'h0);
    txn("t2.wr", 1'b0, 1'b1, 16'h0020, 16'hBEEF, 16'h0);
    txn("t2.rd", 1'b1, 1'b1, 16'h0020, 16'h0, 16'h0);
    txn("t2.rdn", 1'b1, 1'b1, 16'h0021, 16'h0, 16'h0);

    txn("t3.vec", 1'b0, 1'b0, 16'h0020, 16'h7777, 16'h00A5);
    txn("t3.rd", 1'b1, 1'b1, 16'h0020, 16'h0, 16'h0);

    txn("t4.wrw", 1'b0, 1'b1, 16'h0FFF, 16'h3333, 16'h0);
    txn("t4.err", 1'b0, 1'b1, 16'hFFFF, 16'h5555, 16'h0);
    txn("t4.rdw", 1'b1, 1'b1, 16'h0FFF, 16'h0, 16'h0);
    txn("t4.rderr", 1'b1, 1'b1, 16'h1000, 16'h0, 16'h0);
    txn("t4.vecoor", 1'b1, 1'b0, 16'hFFFF, 16'h0, 16'h5A5A);

    abort_txn(16'h0020, 16'hDEAD, 1);
    txn("t5.rd", 1'b1, 1'b1, 16'h0020, 16'h0, 16'h0);

    clr_at_write_entry(16'h0021, 16'h9999);
    txn("clrwr.rd", 1'b1, 1'b1, 16'h0021, 16'h0, 16'h0);

    clr_in_read_ack(16'h0010);
    txn("t6.rd", 1'b1, 1'b1, 16'h0010, 16'h0, 16'h0);

    ztxn("z.wr", 1'b0, 16'h0005, 16'h7777, 16'h0000);
    ztxn("z.rd", 1'b1, 16'h0005, 16'h0000, 16'h7777);
    ztxn("z.wr2", 1'b0, 16'h0005, 16'h0C0C, 16'h0000);
    ztxn("z.rd2", 1'b1, 16'h0005, 16'h0000, 16'h0C0C);

    for (int i = 0; i < 150; i++) begin
      r  = int'($urandom_range(0, 9));
      a  = 16'(16'h0100 + $urandom_range(0, 15));
      wd = 16'($urandom);
      v  = 16'($urandom);
      case (r)
        0: txn("rnd.vec", 1'($urandom), 1'b0, 16'($urandom), wd, v);
        1: txn("rnd.err", 1'($urandom), 1'b1, 16'(DEPTH + $urandom_range(0, 16'hFFFF - DEPTH)), wd, v);
        2: abort_txn(a, wd, int'($urandom_range(0, WC - 1)));
        default: txn("rnd.rw", 1'($urandom), 1'b1, a, wd, v);
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
